// File: rtl/tlc_pkg.sv
// Shared definitions for the demand-driven traffic light scheduler:
// light codes, phase encoding and default phase durations.
package tlc_pkg;

  localparam logic [3:0] LIGHT_RED    = 4'd1;
  localparam logic [3:0] LIGHT_GREEN  = 4'd2;
  localparam logic [3:0] LIGHT_YELLOW = 4'd4;

  localparam int DEF_MIN_GREEN = 8;
  localparam int DEF_MAX_GREEN = 15;
  localparam int DEF_YELLOW    = 3;
  localparam int DEF_ALL_RED   = 3;
  localparam int DEF_CNT_W     = 4;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } phase_t;

  function automatic logic [3:0] ns_light(input phase_t p);
    logic [3:0] code;
    case (p)
      NS_GREEN:  code = LIGHT_GREEN;
      NS_YELLOW: code = LIGHT_YELLOW;
      default:   code = LIGHT_RED;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] ew_light(input phase_t p);
    logic [3:0] code;
    case (p)
      EW_GREEN:  code = LIGHT_GREEN;
      EW_YELLOW: code = LIGHT_YELLOW;
      default:   code = LIGHT_RED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tlc_demand_scheduler_if.sv
// Demand/light bundle between the scheduler and its detectors/signal heads.
// Preemption signals exist only when TLC_PREEMPT_EN is defined.
interface tlc_demand_scheduler_if;
  logic       ns_req;
  logic       ew_req;
  logic [3:0] north_south;
  logic [3:0] east_west;
  logic [2:0] phase;
  logic       ns_ack;
  logic       ew_ack;
`ifdef TLC_PREEMPT_EN
  logic       preempt_req;
  logic       preempt_dir;
  logic       preempt_active;
`endif

  modport master (
    output ns_req, ew_req,
`ifdef TLC_PREEMPT_EN
    output preempt_req, preempt_dir,
    input  preempt_active,
`endif
    input  north_south, east_west, phase, ns_ack, ew_ack
  );

  modport slave (
    input  ns_req, ew_req,
`ifdef TLC_PREEMPT_EN
    input  preempt_req, preempt_dir,
    output preempt_active,
`endif
    output north_south, east_west, phase, ns_ack, ew_ack
  );
endinterface

// File: rtl/tlc_phase_timer.sv
// Phase timer: cleared on a phase change, otherwise counts up and
// saturates at SAT so long green rests never wrap.
module tlc_phase_timer #(
  parameter int CNT_W = 4,
  parameter int SAT   = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] t
);

  logic [CNT_W-1:0] t_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      t_reg <= '0;
    end else if (t_reg != CNT_W'(SAT)) begin
      t_reg <= t_reg + CNT_W'(1);
    end
  end

  assign t = t_reg;

endmodule

// File: rtl/tlc_demand_scheduler.sv
// Two-way demand-actuated traffic light scheduler with min/max green.
// Optional emergency preemption is compiled in with TLC_PREEMPT_EN.
module tlc_demand_scheduler
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW    = DEF_YELLOW,
  parameter int ALL_RED   = DEF_ALL_RED,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  tlc_demand_scheduler_if.slave bus
);

  phase_t           phase_reg, phase_next;
  logic [3:0]       ns_light_reg, ew_light_reg;
  logic             ns_pend_reg, ew_pend_reg;
  logic             ns_ack_reg, ew_ack_reg;
  logic [CNT_W-1:0] t;
  logic             advance;
  logic             demand_ns_leave, demand_ew_leave;
  logic             leave_ns, leave_ew;

  tlc_phase_timer #(
    .CNT_W (CNT_W),
    .SAT   (MAX_GREEN - 1)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (advance),
    .t     (t)
  );

`ifdef TLC_PREEMPT_EN
  logic preempt_reg;
  logic preempt_ns, preempt_ew;
  assign preempt_ns = bus.preempt_req && !bus.preempt_dir;
  assign preempt_ew = bus.preempt_req &&  bus.preempt_dir;
  assign bus.preempt_active = preempt_reg;
`endif

  // Green yields only to a latched opposite demand; own demand extends up to max.
  always_comb begin
    demand_ns_leave = ew_pend_reg &&
                      ((t >= CNT_W'(MIN_GREEN - 1) && !bus.ns_req) || t >= CNT_W'(MAX_GREEN - 1));
    demand_ew_leave = ns_pend_reg &&
                      ((t >= CNT_W'(MIN_GREEN - 1) && !bus.ew_req) || t >= CNT_W'(MAX_GREEN - 1));
`ifdef TLC_PREEMPT_EN
    leave_ns = preempt_ew || (!preempt_ns && demand_ns_leave);
    leave_ew = preempt_ns || (!preempt_ew && demand_ew_leave);
`else
    leave_ns = demand_ns_leave;
    leave_ew = demand_ew_leave;
`endif
  end

  always_comb begin
    phase_next = phase_reg;
    case (phase_reg)
      NS_GREEN:  if (leave_ns)                       phase_next = NS_YELLOW;
      NS_YELLOW: if (t == CNT_W'(YELLOW - 1))        phase_next = ALL_RED_A;
      ALL_RED_A: if (t == CNT_W'(ALL_RED - 1))       phase_next = EW_GREEN;
      EW_GREEN:  if (leave_ew)                       phase_next = EW_YELLOW;
      EW_YELLOW: if (t == CNT_W'(YELLOW - 1))        phase_next = ALL_RED_B;
      ALL_RED_B: if (t == CNT_W'(ALL_RED - 1))       phase_next = NS_GREEN;
      default:                                       phase_next = ALL_RED_B;
    endcase
  end

  assign advance = (phase_next != phase_reg);

  // Lights and acks are derived from the next phase so they change on the same edge as phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_reg    <= ALL_RED_B;
      ns_light_reg <= LIGHT_RED;
      ew_light_reg <= LIGHT_RED;
      ns_pend_reg  <= 1'b0;
      ew_pend_reg  <= 1'b0;
      ns_ack_reg   <= 1'b0;
      ew_ack_reg   <= 1'b0;
`ifdef TLC_PREEMPT_EN
      preempt_reg  <= 1'b0;
`endif
    end else begin
      phase_reg    <= phase_next;
      ns_light_reg <= ns_light(phase_next);
      ew_light_reg <= ew_light(phase_next);
      ns_pend_reg  <= (phase_reg == NS_GREEN) ? 1'b0 : (ns_pend_reg | bus.ns_req);
      ew_pend_reg  <= (phase_reg == EW_GREEN) ? 1'b0 : (ew_pend_reg | bus.ew_req);
      ns_ack_reg   <= (phase_next == NS_GREEN) && (phase_reg != NS_GREEN) &&
                      (ns_pend_reg | bus.ns_req);
      ew_ack_reg   <= (phase_next == EW_GREEN) && (phase_reg != EW_GREEN) &&
                      (ew_pend_reg | bus.ew_req);
`ifdef TLC_PREEMPT_EN
      preempt_reg  <= bus.preempt_req;
`endif
    end
  end

  assign bus.phase       = phase_reg;
  assign bus.north_south = ns_light_reg;
  assign bus.east_west   = ew_light_reg;
  assign bus.ns_ack      = ns_ack_reg;
  assign bus.ew_ack      = ew_ack_reg;

endmodule
